irq_timer_bank: RTL and testbench

Parametrised bank of periodic interrupt timers that generalises the MCU board's fixed single-rate external-interrupt generator. It sits beside `yrv_mcu` in the board top, clocked by the board clock:
- Each of `N_CH` channels divides the clock by a runtime-programmable period.
- Each channel raises a sticky pending flag, held clear by a level-sensitive clear line driven from an MCU port bit.
- Unmasked pending flags are ORed onto the MCU's `ei_req`.

---
 rtl/irq_timer_bank.sv | 88 ++++++++
 tb/tb_irq_timer_bank.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/irq_timer_bank.sv
// Bank of N_CH periodic interrupt timers with sticky pending flags ORed onto ei_req.
// Define IRQ_TIMER_OVERRUN_EN to build per-channel sticky overrun flags; otherwise overrun is tied to 0.
module irq_timer_ch #(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 6249
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             tick,
  output logic             pend,
  output logic             ovr
);
  logic [CNT_W-1:0] cnt, period;

  // cnt never passes period, so all-ones periods cannot wrap
  assign tick = en & (cnt == period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      period <= CNT_W'(DEFAULT_PERIOD);
      pend   <= 1'b0;
    end else begin
      if (wr) period <= wr_data;
      // a tick coinciding with a write still counts; the write only restarts the count
      if (wr || !en || tick) cnt <= '0;
      else                   cnt <= cnt + CNT_W'(1);
      pend <= ~clr & (tick | pend);
    end
  end

`ifdef IRQ_TIMER_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr <= 1'b0;
    else       ovr <= ~clr & (ovr | (tick & pend));
  end
`else
  assign ovr = 1'b0;
`endif
endmodule

module irq_timer_bank #(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 6249,
  localparam int WCH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   clr,
  input  logic [N_CH-1:0]   mask,
  input  logic              wr_en,
  input  logic [WCH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   overrun,
  output logic              ei_req
);
  logic [N_CH-1:0] wr_hit;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // out-of-range wr_ch matches no channel, so such writes are dropped
    assign wr_hit[i] = wr_en && (wr_ch == WCH_W'(i));

    irq_timer_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .clr     (clr[i]),
      .wr      (wr_hit[i]),
      .wr_data (wr_data),
      .tick    (tick[i]),
      .pend    (pending[i]),
      .ovr     (overrun[i])
    );
  end

  assign ei_req = |(pending & ~mask);
endmodule

// File: tb/tb_irq_timer_bank.sv
// Randomised and directed scoreboard bench for irq_timer_bank (N_CH=2, CNT_W=13).
module tb_irq_timer_bank;
  localparam int N  = 2;
  localparam int W  = 13;
  localparam int DP = 6249;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] en = '0, clr = '0, mask = '0;
  logic         wr_en = 1'b0;
  logic [0:0]   wr_ch = '0;
  logic [W-1:0] wr_data = '0;
  logic [N-1:0] tick, pending, overrun;
  logic         ei_req;

  irq_timer_bank #(.N_CH(N), .CNT_W(W), .DEFAULT_PERIOD(DP)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mask(mask),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .tick(tick), .pending(pending), .overrun(overrun), .ei_req(ei_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] tick, pend, ovr;
    logic         ei;
    int           phase;
    int           rel;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;
  int phase = 0, rel = 0;
  int first_t[8];

  // reference: elapsed enabled cycles per channel versus its terminal count
  int elapsed[N], per[N];
  bit m_pend[N], m_ovr[N];

  function automatic void chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  task automatic step(input logic [N-1:0] e, input logic [N-1:0] c, input logic [N-1:0] m,
                      input logic we = 1'b0, input logic wc = 1'b0, input int wd = 0,
                      input logic r = 1'b0);
    exp_t x;
    bit   t[N];
    @(posedge clk); #1;
    reset = r; en = e; clr = c; mask = m; wr_en = we; wr_ch = wc; wr_data = W'(wd);
    if (r) begin
      for (int i = 0; i < N; i++) begin
        elapsed[i] = 0; per[i] = DP; m_pend[i] = 0; m_ovr[i] = 0;
      end
    end
    x.ei = 1'b0;
    for (int i = 0; i < N; i++) begin
      t[i]      = e[i] && (elapsed[i] == per[i]);
      x.tick[i] = t[i];
      x.pend[i] = m_pend[i];
      x.ovr[i]  = m_ovr[i];
      if (m_pend[i] && !m[i]) x.ei = 1'b1;
    end
    x.phase = phase;
    x.rel   = rel;
    q.push_back(x);
    if (r) rel = 0;
    else begin
      rel++;
      for (int i = 0; i < N; i++) begin
        bit hit;
        hit = we && (int'(wc) == i);
        if (hit) per[i] = wd % (1 << W);
        elapsed[i] = (hit || !e[i] || t[i]) ? 0 : elapsed[i] + 1;
`ifdef IRQ_TIMER_OVERRUN_EN
        m_ovr[i] = !c[i] && (m_ovr[i] || (t[i] && m_pend[i]));
`endif
        m_pend[i] = !c[i] && (t[i] || m_pend[i]);
      end
    end
  endtask

  // monitor: compare every cycle's outputs away from the active edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("tick",    int'(tick),    int'(x.tick));
        chk("pending", int'(pending), int'(x.pend));
        chk("overrun", int'(overrun), int'(x.ovr));
        chk("ei_req",  int'(ei_req),  int'(x.ei));
        if (tick[0] && first_t[x.phase] < 0) first_t[x.phase] = x.rel;
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) first_t[i] = -1;
    for (int i = 0; i < N; i++) begin
      elapsed[i] = 0; per[i] = DP; m_pend[i] = 0; m_ovr[i] = 0;
    end
    // phase 0: held in reset
    repeat (3) step(2'b01, 2'b00, 2'b00, 0, 0, 0, 1'b1);
    // phase 1: default period on ch0 only
    phase = 1;
    repeat (6260) step(2'b01, 2'b00, 2'b00);
    // phase 2: ch1 period 3, one-cycle clear
    phase = 2;
    step(2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 3);
    repeat (16) step(2'b10, 2'b00, 2'b00);
    step(2'b10, 2'b10, 2'b00);
    repeat (8) step(2'b10, 2'b00, 2'b00);
    // phase 3: ch0 period 3, clear held across ticks, then overrun build-up and mask
    phase = 3;
    step(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 3);
    repeat (12) step(2'b01, 2'b01, 2'b00);
    repeat (10) step(2'b01, 2'b00, 2'b00);
    repeat (3) step(2'b01, 2'b00, 2'b01);
    repeat (3) step(2'b01, 2'b00, 2'b00);
    // phase 4: reset, then count to 100 and reset mid-count
    phase = 4;
    step(2'b01, 2'b00, 2'b00, 0, 0, 0, 1'b1);
    repeat (100) step(2'b01, 2'b00, 2'b00);
    repeat (2) step(2'b01, 2'b00, 2'b00, 0, 0, 0, 1'b1);
    // phase 5: first tick after release lands at the default period
    phase = 5;
    repeat (6260) step(2'b01, 2'b00, 2'b00);
    // phase 6: random traffic, including period 0 and occasional resets
    phase = 6;
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] e, c, m;
      int wd;
      e  = N'($urandom);
      c  = ($urandom_range(7) == 0) ? N'($urandom) : '0;
      m  = N'($urandom);
      wd = ($urandom_range(3) == 0) ? int'($urandom_range(8191)) : int'($urandom_range(7));
      step(($urandom_range(9) == 0) ? '0 : (e | 2'b01), c, m,
           ($urandom_range(5) == 0), 1'($urandom), wd, ($urandom_range(499) == 0));
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("first_tick_after_reset", first_t[1], DP);
    chk("first_tick_after_midcount_reset", first_t[5], DP);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
